mc_control_unit: RTL and testbench

- Multicycle MIPS-subset control FSM and successor to the first-generation control unit.
- Drives PC/IR/MAR/MDR enables, register-file addressing, ALU op/sign, operand muxes and the RAM MFA/MFC handshake.
- Adds trap/interrupt sequencing with EPC capture, an illegal-opcode trap, overflow write suppression, load/store sequencing and a parametrised memory-timeout bus-error trap.

---
 rtl/mc_control_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute sequencing, load/store
// handshake with RAM, and trap entry for overflow, illegal opcode, bus timeout and interrupts.
//   state  | meaning
//   RST    | post-reset idle, all outputs low
//   F_*    | instruction fetch: MAR load, RAM request, wait MFC, IR load
//   DECODE | classify instruction
//   EXEC   | ALU operands driven, overflow check
//   WB     | register-file write (or HI/LO load)
//   M_*    | load/store: address, store data, request, wait, MDR load, load writeback
//   TRAP   | EPC capture and PC load from cause vector
module mc_control_unit #(
    parameter int ADDR_W      = 9,
    parameter int OVF_VECTOR  = 448,
    parameter int ILL_VECTOR  = 456,
    parameter int BUS_VECTOR  = 464,
    parameter int NMI_VECTOR  = 472,
    parameter int IRQ_VECTOR  = 480,
    parameter int MFC_TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [3:0]        aluCarryFlags,
    input  logic              ramMFC,
    input  logic              hardwareInterrupt,
    input  logic              maskableInterrupt,
    input  logic              statusIE,
    output logic              pcEnable,
    output logic              irEnable,
    output logic              marEnable,
    output logic              mdrEnable,
    output logic              regFileEnable,
    output logic              regFileRW,
    output logic [4:0]        regFileRS,
    output logic [4:0]        regFileRT,
    output logic [4:0]        regFileRD,
    output logic [3:0]        aluOperation,
    output logic [1:0]        aluSign,
    output logic [1:0]        muxSignals,
    output logic              muxSignals2,
    output logic              muxSignals4,
    output logic              ramMFA,
    output logic              ramRW,
    output logic [1:0]        ramDataSize,
    output logic              pcLoadVector,
    output logic              epcEnable,
    output logic [ADDR_W-1:0] vectorAddr,
    output logic [2:0]        trapCause
);
    localparam int CNT_W = (MFC_TIMEOUT > 2) ? $clog2(MFC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (MFC_TIMEOUT == 0) ? '0 : CNT_W'(MFC_TIMEOUT - 1);

    localparam logic [2:0] C_NONE = 3'd0, C_OVF = 3'd1, C_ILL = 3'd2,
                           C_BUS = 3'd3, C_NMI = 3'd4, C_IRQ = 3'd5;

    typedef enum logic [3:0] {
        S_RST, S_F_MAR, S_F_REQ, S_F_WAIT, S_F_IR, S_DECODE, S_EXEC, S_WB,
        S_M_ADDR, S_M_DATA, S_M_REQ, S_M_WAIT, S_M_MDR, S_M_WB, S_TRAP
    } state_t;

    state_t           state_q;
    logic [2:0]       cause_q;
    logic [CNT_W-1:0] cnt_q;

    logic       legal, is_itype, is_lw, is_sw, ovf_chk, hilo, sext;
    logic [3:0] alu_op;
    logic [1:0] alu_sign;
    logic [2:0] end_cause;
    logic       tmo;
    logic       unused_bits;

    assign unused_bits = ^{aluCarryFlags[3:1], instruction[10:6]};

    always_comb begin
        legal = 1'b0; is_itype = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
        ovf_chk = 1'b0; hilo = 1'b0; sext = 1'b0;
        alu_op = 4'b0000; alu_sign = 2'b00;
        if (instruction[31:26] == 6'b000000) begin
            legal = 1'b1;
            case (instruction[5:0])
                6'b100000: begin alu_op = 4'b0010; alu_sign = 2'b10; ovf_chk = 1'b1; end
                6'b100001: alu_op = 4'b0010;
                6'b100010: begin alu_op = 4'b0010; alu_sign = 2'b11; ovf_chk = 1'b1; end
                6'b100011: begin alu_op = 4'b0010; alu_sign = 2'b01; end
                6'b100100: alu_op = 4'b0100;
                6'b100101: alu_op = 4'b0101;
                6'b100110: alu_op = 4'b0110;
                6'b100111: alu_op = 4'b0111;
                6'b000000: alu_op = 4'b1000;
                6'b000010: alu_op = 4'b1001;
                6'b000011: alu_op = 4'b1010;
                6'b011000: begin alu_op = 4'b1100; alu_sign = 2'b10; hilo = 1'b1; end
                6'b011001: begin alu_op = 4'b1100; hilo = 1'b1; end
                6'b011010: begin alu_op = 4'b1101; alu_sign = 2'b10; hilo = 1'b1; end
                6'b011011: begin alu_op = 4'b1101; hilo = 1'b1; end
                default:   legal = 1'b0;
            endcase
        end else begin
            legal = 1'b1;
            is_itype = 1'b1;
            case (instruction[31:26])
                6'b001000: begin alu_op = 4'b0010; alu_sign = 2'b10; ovf_chk = 1'b1; sext = 1'b1; end
                6'b001001: begin alu_op = 4'b0010; sext = 1'b1; end
                6'b001100: alu_op = 4'b0100;
                6'b001101: alu_op = 4'b0101;
                6'b001111: alu_op = 4'b1110;
                6'b100011: begin alu_op = 4'b0010; sext = 1'b1; is_lw = 1'b1; end
                6'b101011: begin alu_op = 4'b0010; sext = 1'b1; is_sw = 1'b1; end
                default:   legal = 1'b0;
            endcase
        end
    end

    // Interrupts are only sampled here, at instruction boundaries.
    assign end_cause = hardwareInterrupt ? C_NMI :
                       (maskableInterrupt && statusIE) ? C_IRQ : C_NONE;
    assign tmo = (MFC_TIMEOUT != 0) && (cnt_q == '0);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
            cause_q <= C_NONE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_F_MAR: state_q <= S_F_REQ;
                S_F_REQ: begin state_q <= S_F_WAIT; cnt_q <= CNT_LOAD; end
                S_F_WAIT: begin
                    if (ramMFC)   state_q <= S_F_IR;
                    else if (tmo) begin state_q <= S_TRAP; cause_q <= C_BUS; end
                    else          cnt_q <= cnt_q - 1'b1;
                end
                S_F_IR: state_q <= S_DECODE;
                S_DECODE: begin
                    if (!legal)             begin state_q <= S_TRAP; cause_q <= C_ILL; end
                    else if (is_lw || is_sw) state_q <= S_M_ADDR;
                    else                     state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (ovf_chk && aluCarryFlags[0]) begin state_q <= S_TRAP; cause_q <= C_OVF; end
                    else                             state_q <= S_WB;
                end
                S_M_ADDR: state_q <= is_sw ? S_M_DATA : S_M_REQ;
                S_M_DATA: state_q <= S_M_REQ;
                S_M_REQ:  begin state_q <= S_M_WAIT; cnt_q <= CNT_LOAD; end
                S_M_WAIT: begin
                    if (ramMFC && is_lw) state_q <= S_M_MDR;
                    else if (ramMFC) begin
                        state_q <= (end_cause != C_NONE) ? S_TRAP : S_F_MAR;
                        if (end_cause != C_NONE) cause_q <= end_cause;
                    end
                    else if (tmo) begin state_q <= S_TRAP; cause_q <= C_BUS; end
                    else          cnt_q <= cnt_q - 1'b1;
                end
                S_M_MDR: state_q <= S_M_WB;
                S_WB, S_M_WB: begin
                    state_q <= (end_cause != C_NONE) ? S_TRAP : S_F_MAR;
                    if (end_cause != C_NONE) cause_q <= end_cause;
                end
                default: state_q <= S_F_MAR;
            endcase
        end
    end

    always_comb begin
        pcEnable = 1'b0; irEnable = 1'b0; marEnable = 1'b0; mdrEnable = 1'b0;
        regFileEnable = 1'b0; regFileRW = 1'b0;
        regFileRS = '0; regFileRT = '0; regFileRD = '0;
        aluOperation = 4'b0000; aluSign = 2'b00; muxSignals = 2'b00;
        muxSignals2 = 1'b0; muxSignals4 = 1'b0;
        ramMFA = 1'b0; ramRW = 1'b0; ramDataSize = 2'b00;
        pcLoadVector = 1'b0; epcEnable = 1'b0; vectorAddr = '0;
        trapCause = cause_q;
        if (state_q inside {S_DECODE, S_EXEC, S_WB, S_M_ADDR, S_M_DATA, S_M_REQ,
                            S_M_WAIT, S_M_MDR, S_M_WB}) begin
            regFileRS = instruction[25:21];
            regFileRT = instruction[20:16];
            regFileRD = is_itype ? instruction[20:16] : instruction[15:11];
        end
        case (state_q)
            S_F_MAR: begin marEnable = 1'b1; muxSignals = 2'b11; end
            S_F_REQ: begin
                pcEnable = 1'b1; aluOperation = 4'b1011; muxSignals = 2'b11;
                ramMFA = 1'b1; ramDataSize = 2'b10;
            end
            S_F_WAIT: begin ramMFA = 1'b1; ramDataSize = 2'b10; end
            S_F_IR:   irEnable = 1'b1;
            S_EXEC, S_WB: begin
                aluOperation = alu_op;
                aluSign      = alu_sign;
                muxSignals   = is_itype ? 2'b01 : 2'b00;
                muxSignals4  = sext;
                if (state_q == S_WB) begin
                    regFileEnable = 1'b1;
                    regFileRW     = !hilo;
                end
            end
            S_M_ADDR: begin
                marEnable = 1'b1; muxSignals = 2'b01; muxSignals4 = 1'b1; aluOperation = 4'b0010;
            end
            S_M_DATA: begin mdrEnable = 1'b1; muxSignals2 = 1'b0; end
            S_M_REQ, S_M_WAIT: begin ramMFA = 1'b1; ramRW = is_sw; ramDataSize = 2'b10; end
            S_M_MDR: begin mdrEnable = 1'b1; muxSignals2 = 1'b1; end
            S_M_WB:  begin regFileEnable = 1'b1; regFileRW = 1'b1; end
            S_TRAP: begin
                epcEnable = 1'b1; pcLoadVector = 1'b1; pcEnable = 1'b1;
                case (cause_q)
                    C_OVF:   vectorAddr = ADDR_W'(OVF_VECTOR);
                    C_ILL:   vectorAddr = ADDR_W'(ILL_VECTOR);
                    C_BUS:   vectorAddr = ADDR_W'(BUS_VECTOR);
                    C_NMI:   vectorAddr = ADDR_W'(NMI_VECTOR);
                    C_IRQ:   vectorAddr = ADDR_W'(IRQ_VECTOR);
                    default: vectorAddr = '0;
                endcase
            end
            default: ;
        endcase
        if (state_q == S_RST) trapCause = cause_q;
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: table of single instructions through fetch/execute,
// plus hand sequences for load/store, memory timeouts and asynchronous reset.
module tb_mc_control_unit;
    logic        Clk, reset;
    logic [31:0] instruction;
    logic [3:0]  aluCarryFlags;
    logic        ramMFC, hardwareInterrupt, maskableInterrupt, statusIE;
    logic        pcEnable, irEnable, marEnable, mdrEnable, regFileEnable, regFileRW;
    logic [4:0]  regFileRS, regFileRT, regFileRD;
    logic [3:0]  aluOperation;
    logic [1:0]  aluSign, muxSignals, ramDataSize;
    logic        muxSignals2, muxSignals4, ramMFA, ramRW, pcLoadVector, epcEnable;
    logic [8:0]  vectorAddr;
    logic [2:0]  trapCause;

    int checks = 0;
    int failures = 0;

    mc_control_unit dut (
        .Clk(Clk), .reset(reset), .instruction(instruction), .aluCarryFlags(aluCarryFlags),
        .ramMFC(ramMFC), .hardwareInterrupt(hardwareInterrupt),
        .maskableInterrupt(maskableInterrupt), .statusIE(statusIE),
        .pcEnable(pcEnable), .irEnable(irEnable), .marEnable(marEnable), .mdrEnable(mdrEnable),
        .regFileEnable(regFileEnable), .regFileRW(regFileRW),
        .regFileRS(regFileRS), .regFileRT(regFileRT), .regFileRD(regFileRD),
        .aluOperation(aluOperation), .aluSign(aluSign), .muxSignals(muxSignals),
        .muxSignals2(muxSignals2), .muxSignals4(muxSignals4), .ramMFA(ramMFA), .ramRW(ramRW),
        .ramDataSize(ramDataSize), .pcLoadVector(pcLoadVector), .epcEnable(epcEnable),
        .vectorAddr(vectorAddr), .trapCause(trapCause)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic        ovf, hw, mi, ie;
        logic        ill, ovf_trap;
        logic [4:0]  rd;
        logic [1:0]  sign, mux;
        logic        sext, wbrw;
        logic [2:0]  end_cause;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [8:0] vec_of(input logic [2:0] c);
        case (c)
            3'd1: return 9'd448;
            3'd2: return 9'd456;
            3'd3: return 9'd464;
            3'd4: return 9'd472;
            3'd5: return 9'd480;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({pcEnable, irEnable, marEnable, mdrEnable, regFileEnable, regFileRW,
                    regFileRS, regFileRT, regFileRD, aluOperation, aluSign, muxSignals,
                    muxSignals2, muxSignals4, ramMFA, ramRW, ramDataSize, pcLoadVector,
                    epcEnable, vectorAddr, trapCause});
    endfunction

    task automatic chk_trap(input logic [2:0] c);
        chk("trap_epc", epcEnable, 1);
        chk("trap_pcload", pcLoadVector, 1);
        chk("trap_vector", vectorAddr, vec_of(c));
        chk("trap_cause", trapCause, c);
        chk("trap_no_regwrite", regFileEnable, 0);
    endtask

    // Starts in F_MAR, ends sampled in F_IR; MFC given after wait_n idle wait cycles.
    task automatic fetch(input int wait_n);
        chk("f_mar_mar", marEnable, 1);
        chk("f_mar_mux", muxSignals, 2'b11);
        chk("f_mar_aluop", aluOperation, 4'b0000);
        tick();
        chk("f_req_pc", pcEnable, 1);
        chk("f_req_aluop", aluOperation, 4'b1011);
        chk("f_req_mfa", ramMFA, 1);
        chk("f_req_rw", ramRW, 0);
        tick();
        for (int i = 0; i < wait_n; i++) begin
            chk("f_wait_mfa", ramMFA, 1);
            tick();
        end
        ramMFC = 1'b1;
        chk("f_wait_mfa", ramMFA, 1);
        tick();
        ramMFC = 1'b0;
        chk("f_ir_ir", irEnable, 1);
        chk("f_ir_mfa", ramMFA, 0);
    endtask

    initial begin
        tbl[0]  = '{32'h00221820, 0, 0, 0, 0, 0, 0, 5'd3, 2'b10, 2'b00, 0, 1, 3'd0};
        tbl[1]  = '{32'h00221820, 1, 0, 0, 0, 0, 1, 5'd3, 2'b10, 2'b00, 0, 1, 3'd0};
        tbl[2]  = '{32'hFC000000, 0, 0, 0, 0, 1, 0, 5'd0, 2'b00, 2'b00, 0, 0, 3'd0};
        tbl[3]  = '{32'h00222022, 0, 0, 0, 0, 0, 0, 5'd4, 2'b11, 2'b00, 0, 1, 3'd0};
        tbl[4]  = '{32'h00222023, 1, 0, 0, 0, 0, 0, 5'd4, 2'b01, 2'b00, 0, 1, 3'd0};
        tbl[5]  = '{32'h20220005, 1, 0, 0, 0, 0, 1, 5'd2, 2'b10, 2'b01, 1, 1, 3'd0};
        tbl[6]  = '{32'h24220005, 0, 0, 0, 0, 0, 0, 5'd2, 2'b00, 2'b01, 1, 1, 3'd0};
        tbl[7]  = '{32'h34220005, 0, 0, 0, 0, 0, 0, 5'd2, 2'b00, 2'b01, 0, 1, 3'd0};
        tbl[8]  = '{32'h00220018, 0, 0, 0, 0, 0, 0, 5'd0, 2'b10, 2'b00, 0, 0, 3'd0};
        tbl[9]  = '{32'h00221821, 0, 0, 1, 0, 0, 0, 5'd3, 2'b00, 2'b00, 0, 1, 3'd0};
        tbl[10] = '{32'h00221821, 0, 1, 1, 1, 0, 0, 5'd3, 2'b00, 2'b00, 0, 1, 3'd4};
        tbl[11] = '{32'h00221821, 0, 0, 1, 1, 0, 0, 5'd3, 2'b00, 2'b00, 0, 1, 3'd5};
        tbl[12] = '{32'h00221801, 0, 0, 0, 0, 1, 0, 5'd0, 2'b00, 2'b00, 0, 0, 3'd0};
        tbl[13] = '{32'h00200008, 0, 0, 0, 0, 1, 0, 5'd0, 2'b00, 2'b00, 0, 0, 3'd0};
        tbl[14] = '{32'h00221827, 0, 0, 0, 0, 0, 0, 5'd3, 2'b00, 2'b00, 0, 1, 3'd0};
        tbl[15] = '{32'h20220005, 0, 0, 0, 0, 0, 0, 5'd2, 2'b10, 2'b01, 1, 1, 3'd0};
        tbl[16] = '{32'h00221820, 1, 1, 0, 0, 0, 1, 5'd3, 2'b10, 2'b00, 0, 1, 3'd0};

        reset = 1'b1; instruction = '0; aluCarryFlags = '0; ramMFC = 1'b0;
        hardwareInterrupt = 1'b0; maskableInterrupt = 1'b0; statusIE = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_outputs_zero", all_outs(), 0);
        reset = 1'b0;
        chk("rst_state_outputs_zero", all_outs(), 0);
        tick();

        for (int k = 0; k < 17; k++) begin
            instruction       = tbl[k].instr;
            hardwareInterrupt = tbl[k].hw;
            maskableInterrupt = tbl[k].mi;
            statusIE          = tbl[k].ie;
            fetch(1);
            tick();
            tick();
            if (tbl[k].ill) begin
                chk_trap(3'd2);
            end else begin
                chk("exec_no_write", regFileEnable, 0);
                chk("exec_sign", aluSign, tbl[k].sign);
                chk("exec_mux", muxSignals, tbl[k].mux);
                if (tbl[k].mux == 2'b01) chk("exec_sext", muxSignals4, tbl[k].sext);
                aluCarryFlags = {3'b000, tbl[k].ovf};
                tick();
                aluCarryFlags = '0;
                if (tbl[k].ovf_trap) begin
                    chk_trap(3'd1);
                end else begin
                    chk("wb_enable", regFileEnable, 1);
                    chk("wb_rw", regFileRW, tbl[k].wbrw);
                    chk("wb_rd", regFileRD, tbl[k].rd);
                    chk("wb_sign", aluSign, tbl[k].sign);
                    tick();
                    if (tbl[k].end_cause != 3'd0) chk_trap(tbl[k].end_cause);
                end
            end
            hardwareInterrupt = 1'b0; maskableInterrupt = 1'b0; statusIE = 1'b0;
            if (marEnable !== 1'b1) tick();
            chk("back_to_fetch", marEnable, 1);
        end

        // LW: address, request, wait, MDR load, writeback to rt
        instruction = 32'h8C220004;
        fetch(1);
        tick(); tick();
        chk("lw_addr_mar", marEnable, 1);
        chk("lw_addr_mux", muxSignals, 2'b01);
        chk("lw_addr_sext", muxSignals4, 1);
        tick();
        chk("lw_req_mfa", ramMFA, 1);
        chk("lw_req_rw", ramRW, 0);
        tick();
        chk("lw_wait_mfa", ramMFA, 1);
        ramMFC = 1'b1;
        tick();
        ramMFC = 1'b0;
        chk("lw_mdr_en", mdrEnable, 1);
        chk("lw_mdr_src", muxSignals2, 1);
        tick();
        chk("lw_wb_en", regFileEnable, 1);
        chk("lw_wb_rw", regFileRW, 1);
        chk("lw_wb_rd", regFileRD, 5'd2);
        tick();
        chk("lw_done", marEnable, 1);

        // SW: store data via MDR, write request, no register write
        instruction = 32'hAC220004;
        fetch(1);
        tick(); tick();
        chk("sw_addr_mar", marEnable, 1);
        tick();
        chk("sw_data_mdr", mdrEnable, 1);
        chk("sw_data_src", muxSignals2, 0);
        tick();
        chk("sw_req_mfa", ramMFA, 1);
        chk("sw_req_rw", ramRW, 1);
        tick();
        chk("sw_wait_rw", ramRW, 1);
        chk("sw_wait_nowrite", regFileEnable, 0);
        ramMFC = 1'b1;
        tick();
        ramMFC = 1'b0;
        chk("sw_done", marEnable, 1);
        chk("sw_done_nowrite", regFileEnable, 0);

        // Fetch timeout: 16 wait cycles without MFC
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            chk("ftmo_wait_mfa", ramMFA, 1);
            tick();
        end
        chk_trap(3'd3);
        chk("ftmo_mfa_dropped", ramMFA, 0);
        tick();

        // MFC on the 16th wait cycle completes the fetch
        instruction = 32'h00221821;
        fetch(15);
        tick(); tick(); tick();
        chk("mfc16_wb_en", regFileEnable, 1);
        chk("mfc16_wb_rd", regFileRD, 5'd3);
        tick();
        chk("mfc16_done", marEnable, 1);

        // LW data phase timeout
        instruction = 32'h8C220004;
        fetch(1);
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 16; i++) begin
            chk("mtmo_wait_mfa", ramMFA, 1);
            tick();
        end
        chk_trap(3'd3);
        chk("mtmo_mfa_dropped", ramMFA, 0);
        tick();

        // Asynchronous reset while in M_WAIT
        fetch(1);
        tick(); tick(); tick(); tick();
        chk("rstmid_in_wait", ramMFA, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_outputs_zero", all_outs(), 0);
        @(negedge Clk);
        reset = 1'b0;
        tick();
        chk("rstmid_restart", marEnable, 1);
        chk("rstmid_cause_clear", trapCause, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
